// File: rtl/button_conditioner.sv
// Button conditioner: synchronises the active-low front-panel buttons to clk,
// debounces them on debounce ticks, and produces level, press and step
// (press plus auto-repeat) outputs per channel.
module button_conditioner #(
    parameter int NUM_BUTTONS  = 6,
    parameter int STABLE_TICKS = 16,
    parameter int HOLD_TICKS   = 5000,
    parameter int REPEAT_TICKS = 1000,
    parameter int CNT_W        = 13
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   tick_in,
    input  logic [NUM_BUTTONS-1:0] buttons_n,
    input  logic [NUM_BUTTONS-1:0] repeat_en,
    output logic [NUM_BUTTONS-1:0] level,
    output logic [NUM_BUTTONS-1:0] press,
    output logic [NUM_BUTTONS-1:0] step
);

    typedef enum logic [2:0] {
        IDLE,
        CONFIRM_PRESS,
        HELD,
        REPEATING,
        CONFIRM_RELEASE
    } state_t;

    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);
    localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_TICKS);
    localparam logic [CNT_W-1:0] HOLD_C   = CNT_W'(HOLD_TICKS);
    localparam logic [CNT_W-1:0] REPEAT_C = CNT_W'(REPEAT_TICKS);

    logic [NUM_BUTTONS-1:0] sync1;
    logic [NUM_BUTTONS-1:0] sync2;
    logic [NUM_BUTTONS-1:0] pressed;
    logic                   tick_d;
    logic                   tick;

    state_t           state      [NUM_BUTTONS];
    state_t           state_next [NUM_BUTTONS];
    logic [CNT_W-1:0] cnt        [NUM_BUTTONS];
    logic [CNT_W-1:0] cnt_next   [NUM_BUTTONS];
    logic [CNT_W-1:0] cnt_inc    [NUM_BUTTONS];

    logic [NUM_BUTTONS-1:0] level_next;
    logic [NUM_BUTTONS-1:0] press_next;
    logic [NUM_BUTTONS-1:0] step_next;

    // Two-flop synchroniser on the raw pins plus tick edge-detect register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= '1;
            sync2  <= '1;
            tick_d <= 1'b1;
        end else begin
            sync1  <= buttons_n;
            sync2  <= sync1;
            tick_d <= tick_in;
        end
    end

    assign pressed = ~sync2;
    assign tick    = tick_in & ~tick_d;

    // Per-channel state, counters and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            level <= '0;
            press <= '0;
            step  <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
                state[i] <= state_next[i];
                cnt[i]   <= cnt_next[i];
            end
            level <= level_next;
            press <= press_next;
            step  <= step_next;
        end
    end

    // Next-state, counter and pulse logic; only tick cycles advance a channel
    always_comb begin
        level_next = level;
        press_next = '0;
        step_next  = '0;
        for (int unsigned i = 0; i < NUM_BUTTONS; i++) begin
            state_next[i] = state[i];
            cnt_next[i]   = cnt[i];
            cnt_inc[i]    = cnt[i] + ONE_C;
            if (tick) begin
                unique case (state[i])
                    IDLE: begin
                        if (pressed[i]) begin
                            if (STABLE_C == ONE_C) begin
                                state_next[i] = HELD;
                                cnt_next[i]   = '0;
                                level_next[i] = 1'b1;
                                press_next[i] = 1'b1;
                                step_next[i]  = 1'b1;
                            end else begin
                                state_next[i] = CONFIRM_PRESS;
                                cnt_next[i]   = ONE_C;
                            end
                        end
                    end
                    CONFIRM_PRESS: begin
                        if (!pressed[i]) begin
                            state_next[i] = IDLE;
                            cnt_next[i]   = '0;
                        end else if (cnt_inc[i] == STABLE_C) begin
                            state_next[i] = HELD;
                            cnt_next[i]   = '0;
                            level_next[i] = 1'b1;
                            press_next[i] = 1'b1;
                            step_next[i]  = 1'b1;
                        end else begin
                            cnt_next[i] = cnt_inc[i];
                        end
                    end
                    HELD, REPEATING: begin
                        if (!pressed[i]) begin
                            if (STABLE_C == ONE_C) begin
                                state_next[i] = IDLE;
                                cnt_next[i]   = '0;
                                level_next[i] = 1'b0;
                            end else begin
                                state_next[i] = CONFIRM_RELEASE;
                                cnt_next[i]   = ONE_C;
                            end
                        end else if (!repeat_en[i]) begin
                            // Saturate so a later re-enable steps on the next tick
                            state_next[i] = HELD;
                            cnt_next[i]   = (state[i] == REPEATING || cnt[i] >= HOLD_C)
                                            ? HOLD_C : cnt_inc[i];
                        end else if (cnt_inc[i] >= ((state[i] == HELD) ? HOLD_C : REPEAT_C)) begin
                            state_next[i] = REPEATING;
                            cnt_next[i]   = '0;
                            step_next[i]  = 1'b1;
                        end else begin
                            cnt_next[i] = cnt_inc[i];
                        end
                    end
                    CONFIRM_RELEASE: begin
                        if (pressed[i]) begin
                            state_next[i] = HELD;
                            cnt_next[i]   = '0;
                        end else if (cnt_inc[i] == STABLE_C) begin
                            state_next[i] = IDLE;
                            cnt_next[i]   = '0;
                            level_next[i] = 1'b0;
                        end else begin
                            cnt_next[i] = cnt_inc[i];
                        end
                    end
                    default: begin
                        state_next[i] = IDLE;
                        cnt_next[i]   = '0;
                        level_next[i] = 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
